gtech_ser8_tx: RTL and testbench

Byte serializer: accepts one 8-bit parallel word per valid/ready handshake and shifts it out on a single serial line, one bit per clock, with a framing strobe. It is the transmit end paired with the 8-bit parallel capture registers of the GTECH set. It converts register-file or datapath bytes into a serial stream for a downstream shift-in capture stage.

---
 rtl/gtech_ser8_tx.sv | 172 +++++++++++++++++
 tb/tb_gtech_ser8_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gtech_ser8_tx.sv
// ---------------------------------------------------------------------------
// gtech_ser8_tx
//
// Byte serializer. One 8-bit word is taken per VALID/READY handshake and
// shifted out on SO, one bit per CP cycle, framed by SOV and LAST.
//
// Parameters:
//   MSB_FIRST  - 0: D[0] leaves first, 1: D[7] leaves first.
//   IDLE_LEVEL - level held on SO whenever no frame is active.
//
// Optional build feature:
//   GTECH_SER8_TX_PARITY_EN - when defined, a ninth frame bit carrying even
//   parity (XOR of the 8 data bits) follows the data; LAST marks that bit.
//
// Ports:
//   CP    in   clock, rising edge active
//   R     in   asynchronous active-high reset
//   D     in   [7:0] parallel data word
//   VALID in   D is offered for transfer
//   READY out  a word is accepted at the next rising edge of CP
//   SO    out  serial data
//   SOV   out  high while SO carries a frame bit
//   LAST  out  high during the final bit of a frame
//
// Handshake: a word transfers on a rising CP edge where VALID and READY are
// both high. READY is a function of state and R only (never of VALID), and
// VALID/D are ignored on every other edge. READY is also high during LAST,
// so frames can run back-to-back with no idle gap.
// ---------------------------------------------------------------------------
module gtech_ser8_tx #(
  parameter int MSB_FIRST  = 0,
  parameter int IDLE_LEVEL = 1
) (
  input  logic       CP,
  input  logic       R,
  input  logic [7:0] D,
  input  logic       VALID,
  output logic       READY,
  output logic       SO,
  output logic       SOV,
  output logic       LAST
);

  // Index of the final frame bit (frame length minus one).
`ifdef GTECH_SER8_TX_PARITY_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

`ifdef GTECH_SER8_TX_PARITY_EN
  // Even parity of the word in flight, captured when the word is loaded.
  logic       par_bit;
  logic       par_nxt;
`endif

  logic       at_last;
  logic       xfer;
  logic       data_bit;
  logic       so_nxt;
  logic       sov_nxt;

  // Outputs below are decoded purely from registers, so there is no
  // combinational path from D or VALID to SO/SOV/LAST.
  assign at_last = (state == ST_SHIFT) && (cnt == LAST_IDX);
  assign READY   = !R && ((state == ST_IDLE) || at_last);
  assign xfer    = VALID && READY;

  // The bit currently presented comes from whichever end of the register the
  // configured order shifts out of.
  assign data_bit = (MSB_FIRST != 0) ? shreg[7] : shreg[0];

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CP or posedge R) begin
    if (R) begin
      state <= ST_IDLE;
      shreg <= 8'h00;
      cnt   <= 4'd0;
`ifdef GTECH_SER8_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
`ifdef GTECH_SER8_TX_PARITY_EN
      par_bit <= par_nxt;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    so_nxt    = (IDLE_LEVEL != 0);
    sov_nxt   = 1'b0;
`ifdef GTECH_SER8_TX_PARITY_EN
    par_nxt   = par_bit;
`endif

    case (state)
      ST_IDLE: begin
        if (xfer) begin
          state_nxt = ST_SHIFT;
          shreg_nxt = D;
          cnt_nxt   = 4'd0;
`ifdef GTECH_SER8_TX_PARITY_EN
          par_nxt   = ^D;
`endif
        end
      end

      ST_SHIFT: begin
        sov_nxt = 1'b1;
`ifdef GTECH_SER8_TX_PARITY_EN
        // After the eight data bits the parity bit takes the line.
        so_nxt  = (cnt == 4'd8) ? par_bit : data_bit;
`else
        so_nxt  = data_bit;
`endif
        if (at_last) begin
          if (xfer) begin
            // Reload on the LAST edge: the next cycle carries bit 0 of the
            // new word, keeping the stream gapless.
            shreg_nxt = D;
            cnt_nxt   = 4'd0;
`ifdef GTECH_SER8_TX_PARITY_EN
            par_nxt   = ^D;
`endif
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
          end
        end else begin
          if (MSB_FIRST != 0) begin
            shreg_nxt = {shreg[6:0], 1'b0};
          end else begin
            shreg_nxt = {1'b0, shreg[7:1]};
          end
          cnt_nxt = cnt + 4'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign SO   = so_nxt;
  assign SOV  = sov_nxt;
  assign LAST = at_last;

endmodule

// File: tb/tb_gtech_ser8_tx.sv
// ---------------------------------------------------------------------------
// tb_gtech_ser8_tx
//
// Drives two serializers from the same clock, reset and input stream: one
// LSB-first (default parameters) and one MSB-first. Every accepted word
// pushes its expected frame bits ({so, last}) onto a per-instance queue; each
// cycle the head is popped and compared against SO/LAST while SOV must be
// high, and an empty queue means the line must sit idle. READY is predicted
// from the queue: a word can be taken when at most the current bit remains.
// ---------------------------------------------------------------------------
module tb_gtech_ser8_tx;

`ifdef GTECH_SER8_TX_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif
  localparam logic IDLE_LVL = 1'b1;

  // ---------------------------------------------------------------- clock/reset
  logic       cp = 1'b0;
  logic       r  = 1'b1;
  logic [7:0] d  = 8'h00;
  logic       valid = 1'b0;

  always #5 cp = ~cp;

  logic ready_l, so_l, sov_l, last_l;
  logic ready_m, so_m, sov_m, last_m;

  gtech_ser8_tx #(.MSB_FIRST(0), .IDLE_LEVEL(1)) dut_lsb (
    .CP(cp), .R(r), .D(d), .VALID(valid),
    .READY(ready_l), .SO(so_l), .SOV(sov_l), .LAST(last_l)
  );

  gtech_ser8_tx #(.MSB_FIRST(1), .IDLE_LEVEL(1)) dut_msb (
    .CP(cp), .R(r), .D(d), .VALID(valid),
    .READY(ready_m), .SO(so_m), .SOV(sov_m), .LAST(last_m)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [1:0] exp_q[$];     // LSB-first instance: {so, last}
  logic [1:0] exp_q_m[$];   // MSB-first instance
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] w);
    logic b_l, b_m, lst;
    for (int i = 0; i < N; i++) begin
      lst = (i == N - 1);
      if (i == 8) begin
        b_l = ^w;
        b_m = ^w;
      end else begin
        b_l = w[i];
        b_m = w[7 - i];
      end
      exp_q.push_back({b_l, lst});
      exp_q_m.push_back({b_m, lst});
    end
  endtask

  // One clock cycle: compare outputs at the falling edge, predict whether the
  // coming rising edge transfers, then step past that edge.
  task automatic cycle();
    logic [1:0] e;
    logic       xfer;
    @(negedge cp);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lsb_so", so_l, e[1]);
      chk("lsb_sov", sov_l, 1'b1);
      chk("lsb_last", last_l, e[0]);
    end else begin
      chk("lsb_idle_so", so_l, IDLE_LVL);
      chk("lsb_idle_sov", sov_l, 1'b0);
      chk("lsb_idle_last", last_l, 1'b0);
    end
    if (exp_q_m.size() > 0) begin
      e = exp_q_m.pop_front();
      chk("msb_so", so_m, e[1]);
      chk("msb_sov", sov_m, 1'b1);
      chk("msb_last", last_m, e[0]);
    end else begin
      chk("msb_idle_so", so_m, IDLE_LVL);
      chk("msb_idle_sov", sov_m, 1'b0);
      chk("msb_idle_last", last_m, 1'b0);
    end
    chk("lsb_ready", ready_l, !r && (exp_q.size() == 0));
    chk("msb_ready", ready_m, !r && (exp_q_m.size() == 0));
    xfer = !r && valid && (exp_q.size() == 0);
    @(posedge cp);
    if (xfer) push_frame(d);
    #1;
  endtask

  task automatic send(input logic [7:0] w, input int idle_after);
    d = w;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    d = 8'($urandom_range(0, 255));
    repeat (N + idle_after) cycle();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // Reset held: idle line, READY low.
    repeat (3) cycle();
    r = 1'b0;
    // READY rises in the same cycle reset drops.
    repeat (2) cycle();

    // Single words, including ones whose two bit orders differ.
    send(8'hA5, 2);
    send(8'h81, 2);
    send(8'h0F, 1);
    send(8'h07, 1);
    send(8'h03, 1);

    // Back-to-back: VALID held, second word accepted on the LAST edge.
    d = 8'hFF;
    valid = 1'b1;
    cycle();
    d = 8'h00;
    repeat (N) cycle();
    valid = 1'b0;
    repeat (N + 2) cycle();

    // Hold-off: VALID high with D churning mid-frame must not disturb it.
    d = 8'h3C;
    valid = 1'b1;
    cycle();
    repeat (N - 1) begin
      d = 8'($urandom_range(0, 255));
      cycle();
    end
    valid = 1'b0;
    repeat (3) cycle();

    // Random traffic.
    repeat (60) begin
      valid = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      cycle();
    end
    valid = 1'b0;
    repeat (N + 1) cycle();

    // Reset mid-frame aborts at once, no leftover bits afterwards.
    d = 8'h5A;
    valid = 1'b1;
    cycle();
    valid = 1'b0;
    repeat (3) cycle();
    r = 1'b1;
    exp_q.delete();
    exp_q_m.delete();
    repeat (2) cycle();
    r = 1'b0;
    repeat (N + 2) cycle();

    // Clean word after the abort.
    send(8'hC6, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
